// File: rtl/comma_aligner.sv
// Receive-side symbol aligner: hunts the K28.5 comma in a serial bit stream,
// locks the 10-bit boundary to it and emits aligned symbols to the 8b/10b decoder.
//
// state   | meaning
// HUNT    | no boundary known, searching every bit position for a comma
// CHECK   | boundary tentatively set, counting consecutive aligned commas
// LOCKED  | boundary confirmed, counting consecutive misaligned commas
module comma_aligner #(
    parameter int P_LOCK_CNT = 3,
    parameter int P_LOSS_CNT = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Bit,
    input  logic       i_Bit_Valid,
    output logic [9:0] o_Symbol,
    output logic       o_Sym_Valid,
    output logic       o_Is_Comma,
    output logic       o_Locked,
    output logic       o_Realign
);

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [3:0] LOCK_CNT  = 4'(P_LOCK_CNT);
    localparam logic [3:0] LOSS_CNT  = 4'(P_LOSS_CNT);

    typedef enum logic [1:0] {ST_HUNT, ST_CHECK, ST_LOCKED} state_t;

    state_t     state_q, state_d;
    logic [9:0] sr_q, sr_d;
    logic [9:0] sym_q, sym_d;
    logic [3:0] fill_q, fill_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic       sym_valid_q, sym_valid_d;
    logic       is_comma_q, is_comma_d;
    logic       realign_q, realign_d;

    logic [9:0] nsr;
    logic       comma;
    logic       boundary;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        nsr      = {sr_q[8:0], i_Bit};
        // fill gating keeps the reset zeros from completing a false comma
        comma    = i_Bit_Valid && (fill_q >= 4'd9) &&
                   ((nsr == K28_5_RDN) || (nsr == K28_5_RDP));
        boundary = i_Bit_Valid && (bit_cnt_q == 4'd9);

        state_d     = state_q;
        sr_d        = sr_q;
        sym_d       = sym_q;
        fill_d      = fill_q;
        bit_cnt_d   = bit_cnt_q;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        is_comma_d  = is_comma_q;
        sym_valid_d = 1'b0;
        realign_d   = 1'b0;

        if (i_Bit_Valid) begin
            sr_d      = nsr;
            fill_d    = (fill_q == 4'd10) ? fill_q : fill_q + 4'd1;
            bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;

            case (state_q)
                ST_HUNT: begin
                    if (comma) begin
                        bit_cnt_d   = 4'd0;
                        sym_d       = nsr;
                        is_comma_d  = 1'b1;
                        sym_valid_d = 1'b1;
                        realign_d   = 1'b1;
                        comma_cnt_d = 4'd1;
                        state_d     = (LOCK_CNT == 4'd1) ? ST_LOCKED : ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (boundary) begin
                        sym_d       = nsr;
                        is_comma_d  = comma;
                        sym_valid_d = 1'b1;
                        if (comma) begin
                            comma_cnt_d = sat_inc(comma_cnt_q);
                            if (sat_inc(comma_cnt_q) >= LOCK_CNT) state_d = ST_LOCKED;
                        end else begin
                            comma_cnt_d = 4'd0;
                            state_d     = ST_HUNT;
                        end
                    end else if (comma) begin
                        bit_cnt_d   = 4'd0;
                        sym_d       = nsr;
                        is_comma_d  = 1'b1;
                        sym_valid_d = 1'b1;
                        realign_d   = 1'b1;
                        comma_cnt_d = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        sym_d       = nsr;
                        is_comma_d  = comma;
                        sym_valid_d = 1'b1;
                    end
                    // a misaligned comma is only counted; the boundary stays put
                    if (comma && boundary) begin
                        err_cnt_d = 4'd0;
                    end else if (comma) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                        if (sat_inc(err_cnt_q) >= LOSS_CNT) begin
                            err_cnt_d   = 4'd0;
                            comma_cnt_d = 4'd0;
                            state_d     = ST_HUNT;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_HUNT;
            sr_q        <= '0;
            sym_q       <= '0;
            fill_q      <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            err_cnt_q   <= '0;
            sym_valid_q <= 1'b0;
            is_comma_q  <= 1'b0;
            realign_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            sym_q       <= sym_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            err_cnt_q   <= err_cnt_d;
            sym_valid_q <= sym_valid_d;
            is_comma_q  <= is_comma_d;
            realign_q   <= realign_d;
        end
    end

    assign o_Symbol    = sym_q;
    assign o_Sym_Valid = sym_valid_q;
    assign o_Is_Comma  = is_comma_q;
    assign o_Realign   = realign_q;
    assign o_Locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_comma_aligner.sv
// Self-checking bench for comma_aligner: directed table, corner-case sequences
// and randomized streams compared cycle by cycle with a behavioural model.
module tb_comma_aligner;

    localparam int         LOCK_N = 3;
    localparam int         LOSS_N = 4;
    localparam logic [9:0] K_M    = 10'b0011111010;
    localparam logic [9:0] K_P    = 10'b1100000101;
    localparam logic [9:0] D21_5  = 10'b1010101010;
    localparam int         M_HUNT = 0, M_CHECK = 1, M_LOCK = 2;

    logic       clk;
    logic       rst_n;
    logic       i_Bit;
    logic       i_Bit_Valid;
    logic [9:0] o_Symbol;
    logic       o_Sym_Valid, o_Is_Comma, o_Locked, o_Realign;

    int checks = 0;
    int errors = 0;

    comma_aligner #(.P_LOCK_CNT(LOCK_N), .P_LOSS_CNT(LOSS_N)) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Bit      (i_Bit),
        .i_Bit_Valid(i_Bit_Valid),
        .o_Symbol   (o_Symbol),
        .o_Sym_Valid(o_Sym_Valid),
        .o_Is_Comma (o_Is_Comma),
        .o_Locked   (o_Locked),
        .o_Realign  (o_Realign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: absolute bit index since reset, boundary anchored to
    // the bit index of the last realignment
    bit         m_q[$];
    int         m_n, m_anchor, m_mode, m_cnt, m_err;
    logic [9:0] e_sym;
    logic       e_sv, e_cm, e_rl;

    function automatic void m_reset();
        m_q.delete();
        m_n = 0; m_anchor = 0; m_mode = M_HUNT; m_cnt = 0; m_err = 0;
        e_sym = '0; e_sv = 0; e_cm = 0; e_rl = 0;
    endfunction

    function automatic void m_emit(input logic [9:0] w, input logic c);
        e_sym = w; e_cm = c; e_sv = 1;
    endfunction

    function automatic void m_step(input logic b, input logic v);
        logic [9:0] w;
        bit         is_c, on_b;
        e_sv = 0; e_rl = 0;
        if (!v) return;
        m_q.push_back(b);
        if (m_q.size() > 10) void'(m_q.pop_front());
        m_n++;
        w = '0;
        foreach (m_q[i]) w = {w[8:0], m_q[i]};
        is_c = (m_n >= 10) && (w == K_M || w == K_P);
        on_b = ((m_n - m_anchor) % 10) == 0;
        if (m_mode == M_HUNT) begin
            if (is_c) begin
                m_anchor = m_n; m_emit(w, 1); e_rl = 1; m_cnt = 1;
                m_mode = (LOCK_N == 1) ? M_LOCK : M_CHECK;
            end
        end else if (m_mode == M_CHECK) begin
            if (on_b) begin
                m_emit(w, is_c);
                if (is_c) begin
                    m_cnt++;
                    if (m_cnt >= LOCK_N) m_mode = M_LOCK;
                end else begin
                    m_cnt = 0; m_mode = M_HUNT;
                end
            end else if (is_c) begin
                m_anchor = m_n; m_emit(w, 1); e_rl = 1; m_cnt = 1;
            end
        end else begin
            if (on_b) m_emit(w, is_c);
            if (is_c && on_b) m_err = 0;
            else if (is_c) begin
                m_err++;
                if (m_err >= LOSS_N) begin m_err = 0; m_cnt = 0; m_mode = M_HUNT; end
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic b, input logic v);
        @(negedge clk);
        i_Bit = b; i_Bit_Valid = v;
        @(posedge clk);
        m_step(b, v);
        #1;
        chk("model_sym_valid", o_Sym_Valid, e_sv);
        chk("model_realign", o_Realign, e_rl);
        chk("model_locked", o_Locked, (m_mode == M_LOCK));
        if (e_sv) begin
            chk("model_symbol", o_Symbol, e_sym);
            chk("model_is_comma", o_Is_Comma, e_cm);
        end
    endtask

    task automatic send_pat(input logic [9:0] pat, input int nb, input bit bub);
        for (int i = 0; i < nb; i++) begin
            if (bub) step(1'b1, 1'b0);
            step(pat[nb-1-i], 1'b1);
        end
    endtask

    task automatic send_rnd(input logic [9:0] pat, input int nb);
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) step(1'($urandom_range(0, 1)), 1'b0);
            step(pat[nb-1-i], 1'b1);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_symbol"}, o_Symbol, 0);
        chk({nm, "_sym_valid"}, o_Sym_Valid, 0);
        chk({nm, "_is_comma"}, o_Is_Comma, 0);
        chk({nm, "_locked"}, o_Locked, 0);
        chk({nm, "_realign"}, o_Realign, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_Bit = 1'($urandom_range(0, 1)); i_Bit_Valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 chk_all_zero("reset_hold");
        end
        @(negedge clk);
        i_Bit_Valid = 1'b0;
        rst_n = 1'b1;
        m_reset();
    endtask

    typedef struct {
        logic [9:0] pat;
        int         nb;
        logic       e_sv, e_cm, e_lk, e_rl;
    } vec_t;

    vec_t tbl[4];
    logic [9:0] pre8;

    initial begin
        tbl[0] = '{pat: 10'b101, nb: 3,  e_sv: 0, e_cm: 0, e_lk: 0, e_rl: 0};
        tbl[1] = '{pat: K_M,     nb: 10, e_sv: 1, e_cm: 1, e_lk: 0, e_rl: 1};
        tbl[2] = '{pat: K_P,     nb: 10, e_sv: 1, e_cm: 1, e_lk: 0, e_rl: 0};
        tbl[3] = '{pat: K_M,     nb: 10, e_sv: 1, e_cm: 1, e_lk: 1, e_rl: 0};

        rst_n = 1'b0; i_Bit = 1'b0; i_Bit_Valid = 1'b0;
        m_reset();

        // reset with toggling inputs, then 8 bits that look like a comma prefix
        do_reset();
        pre8 = 10'b0000111110;
        send_pat(pre8, 8, 0);
        chk("fill_gate_realign", o_Realign, 0);
        chk("fill_gate_sym_valid", o_Sym_Valid, 0);

        // acquisition table
        do_reset();
        foreach (tbl[k]) begin
            send_pat(tbl[k].pat, tbl[k].nb, 0);
            chk("tbl_sym_valid", o_Sym_Valid, tbl[k].e_sv);
            chk("tbl_locked", o_Locked, tbl[k].e_lk);
            chk("tbl_realign", o_Realign, tbl[k].e_rl);
            if (tbl[k].e_sv) begin
                chk("tbl_is_comma", o_Is_Comma, tbl[k].e_cm);
                chk("tbl_symbol", o_Symbol, tbl[k].pat);
            end
        end
        step(1'b0, 1'b0);
        chk("locked_after_third", o_Locked, 1);

        // data with bubbles keeps lock and is delivered intact
        for (int s = 0; s < 5; s++) begin
            send_pat(D21_5, 10, 1);
            chk("d215_sym_valid", o_Sym_Valid, 1);
            chk("d215_symbol", o_Symbol, D21_5);
            chk("d215_is_comma", o_Is_Comma, 0);
            chk("d215_locked", o_Locked, 1);
        end

        // one slipped bit, then misaligned commas until lock is lost
        step(1'b0, 1'b1);
        for (int c = 1; c <= LOSS_N; c++) begin
            send_pat(K_M, 10, 0);
            chk("slip_locked", o_Locked, (c < LOSS_N));
        end
        send_pat(K_M, 10, 0);
        chk("reacquire_realign", o_Realign, 1);
        chk("reacquire_is_comma", o_Is_Comma, 1);

        // CHECK sees data at its boundary and falls back to HUNT
        do_reset();
        send_pat(10'b101, 3, 0);
        send_pat(K_M, 10, 0);
        send_pat(D21_5, 10, 0);
        chk("check_fail_sym_valid", o_Sym_Valid, 1);
        chk("check_fail_is_comma", o_Is_Comma, 0);
        send_pat(D21_5, 10, 0);
        chk("hunt_no_emit", o_Sym_Valid, 0);

        // off-boundary comma in CHECK restarts the count at 1
        do_reset();
        send_pat(10'b101, 3, 0);
        send_pat(K_M, 10, 0);
        send_pat(10'b0011111010, 9, 0);
        chk("check_realign", o_Realign, 1);
        chk("check_realign_comma", o_Is_Comma, 1);
        send_pat(K_M, 10, 0);
        chk("check_restart_not_locked", o_Locked, 0);
        send_pat(K_M, 10, 0);
        chk("check_restart_locked", o_Locked, 1);

        // asynchronous reset mid-symbol, then full relock
        send_pat(K_M, 4, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk);
        #1 chk_all_zero("async_reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        send_pat(10'b101, 3, 0);
        send_pat(K_M, 10, 0);
        send_pat(K_P, 10, 0);
        chk("relock_second_not_locked", o_Locked, 0);
        send_pat(K_M, 10, 0);
        chk("relock_third_locked", o_Locked, 1);

        // randomized streams against the model
        do_reset();
        for (int it = 0; it < 400; it++) begin
            int         r, nb;
            logic [9:0] pat;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                pat = ($urandom_range(0, 1) != 0) ? K_P : K_M;
                nb  = 10;
            end else if (r < 8) begin
                pat = 10'($urandom);
                nb  = $urandom_range(1, 3);
            end else begin
                pat = 10'($urandom);
                nb  = 10;
            end
            send_rnd(pat, nb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
- Receive-side symbol aligner between the serial bit stream (the output of the async FIFO read side) and the 8b/10b decoder.
- Accepts one bit per qualified clock and hunts for the K28.5 comma in either running disparity.
- Locks the 10-bit symbol boundary to the comma, then presents aligned 10-bit symbols with a one-cycle valid strobe.
- Supervises lock with a hunt/check/locked state machine.

Parameters:
- P_LOCK_CNT, 3, number of consecutive boundary-aligned commas (the first included) needed to enter LOCKED; legal range 1..15.
- P_LOSS_CNT, 4, number of consecutive misaligned commas in LOCKED that force a return to HUNT; legal range 1..15.

Ports:
- i_Clk  in  1  single clock for all logic.
- i_Rst_n  in  1  reset, asynchronous assert, active-low.
- i_Bit  in  1  serial data bit, first-transmitted bit first.
- i_Bit_Valid  in  1  i_Bit is sampled on a rising edge only when this is high.
- o_Symbol  out  10  aligned symbol; the first-received bit is at [9], so [9:4] is the 6b sub-block and [3:0] is the 4b sub-block.
- o_Sym_Valid  out  1  one-cycle pulse: o_Symbol is new.
- o_Is_Comma  out  1  qualifies o_Symbol as K28.5; valid only with o_Sym_Valid.
- o_Locked  out  1  high while in LOCKED.
- o_Realign  out  1  one-cycle pulse whenever the boundary is moved.

Behaviour:
- Reset (async, i_Rst_n=0):
  - All outputs are 0.
  - Shift register is 0, fill counter is 0, bit counter is 0, comma/error counters are 0, state is HUNT.
- Shift and match:
  - On each edge with i_Bit_Valid=1: nsr = {sr[8:0], i_Bit}, and sr <= nsr.
  - Fill counter saturates at 10.
  - comma = (fill>=9 before the shift) && (nsr==10'b0011111010 || nsr==10'b1100000101).
  - This gating prevents false matches against reset zeros.
- Cycles with i_Bit_Valid=0:
  - Nothing changes except that the pulse outputs return to 0.
- Bit counter:
  - Counts 0..9 and increments on each valid bit.
  - boundary = (bit_cnt==9) && i_Bit_Valid.
  - When a boundary is taken, or when the boundary is moved, bit_cnt <= 0.
- Symbol emission:
  - On every boundary in CHECK or LOCKED: o_Symbol <= nsr, o_Is_Comma <= comma, o_Sym_Valid <= 1 for exactly one cycle.
  - Latency: the symbol is visible the cycle after its 10th bit is sampled.
- HUNT state:
  - No boundary emission.
  - On comma: bit_cnt <= 0, emit nsr as a comma symbol with Sym_Valid, o_Realign pulse, comma_cnt <= 1.
  - Then go to LOCKED if P_LOCK_CNT==1, otherwise go to CHECK.
- CHECK state:
  - Comma at a boundary: comma_cnt+1; when it reaches P_LOCK_CNT, go to LOCKED.
  - Non-comma at a boundary: go to HUNT, comma_cnt <= 0.
  - Comma off-boundary: realign immediately (bit_cnt <= 0, o_Realign, emit as comma, comma_cnt <= 1), stay in CHECK.
- LOCKED state:
  - o_Locked=1.
  - Comma at a boundary: err_cnt <= 0.
  - Comma off-boundary: err_cnt+1 and the boundary is not moved.
  - When err_cnt reaches P_LOSS_CNT: go to HUNT, o_Locked drops the next cycle, err_cnt <= 0.
  - Non-comma data never affects lock.
- Simultaneous events:
  - A comma at a boundary is on-boundary by definition.
  - The HUNT-to-CHECK transition and the emission happen on the same edge.
- Counters saturate and never wrap.
- Reset mid-stream:
  - All state is cleared and alignment is lost.
  - The fill counter restarts, so 10 new bits are required before any match.

Test Plan:
- Reset held, toggling i_Bit/i_Bit_Valid -> all outputs 0; release, then 8 valid bits of 00111110 -> no comma or realign (fill gating).
- 3 junk bits 101, then K28.5 RD- 0011111010, then K28.5 RD+ 1100000101, then RD- again, all with i_Bit_Valid=1 and P_LOCK_CNT=3:
  - o_Realign on the first comma.
  - o_Sym_Valid exactly every 10 cycles with o_Is_Comma=1.
  - o_Locked=1 the cycle after the third comma symbol.
- While locked, send D21.5 1010101010 x5 interleaved with bubbles (i_Bit_Valid=0 every other cycle) -> symbols emitted intact with Is_Comma=0; spacing is 10 valid bits, not 10 cycles; o_Locked stays 1.
- While locked, insert one extra bit, then 4 commas at the shifted phase (P_LOSS_CNT=4):
  - First 3 commas: no symbol flagged comma, still locked.
  - 4th comma: o_Locked falls, state is HUNT.
  - Next comma re-acquires with o_Realign.
- In CHECK after 1 comma, send D21.5 at a boundary -> returns to HUNT, o_Sym_Valid stops; separately, an off-boundary comma in CHECK -> o_Realign pulse, count restarts at 1 (lock needs 2 more aligned commas).
- Assert i_Rst_n low mid-symbol while locked -> outputs 0 asynchronously (before the next clock edge); after release, relock requires the full HUNT/CHECK sequence.
